status_cond_unit: RTL and testbench
===================================

# status_cond_unit

Holds the architectural NZCV status register, written from the Exe-stage ALU flags when a flag-setting instruction retires through Exe. It evaluates the 4-bit ARM condition field of the instruction in the ID stage against those flags and supplies the carry-in for ADC/SBC to the ALU. It detects read-after-write hazards on the flags, issuing a one-cycle stall rather than forwarding the ALU flags combinationally. It also keeps a saturating flag-stall counter for performance monitoring.

## Interface
- STALL_CNT_W, 16, width of the saturating flag-stall counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- exe_valid  in  1  Exe stage holds a real (non-bubble) instruction
- exe_s  in  1  S bit of the Exe instruction (updates flags)
- alu_n, alu_z, alu_c, alu_v  in  1 each  flags from the ALU this cycle
- id_valid  in  1  ID stage holds a real instruction
- id_cond  in  4  condition field of the ID instruction
- freeze  in  1  global pipeline freeze (memory wait); holds all state
- status  out  4  {N,Z,C,V} register contents
- c_in  out  1  equals status[1]; carry to ALU for ADC/SBC
- cond_pass  out  1  ID instruction's condition holds on current status
- flag_stall  out  1  ID must hold and Exe receives a bubble this cycle
- stall_count  out  STALL_CNT_W  number of cycles flag_stall was asserted

## Operation
- Status write: on the rising edge with freeze=0, exe_valid=1 and exe_s=1, status <= {alu_n,alu_z,alu_c,alu_v}. Otherwise status holds.
- For logical ops and MOV/MVN the ALU drives C=0 and V=0; this block stores what it is given, with no flag masking.
- Condition evaluation, combinational from status (not the ALU flags):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C
  - MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V
  - HI 1000 C&!Z; LS 1001 !C|Z
  - GE 1010 N==V; LT 1011 N!=V
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 1; 1111 reserved, evaluates 0
- Hazard: flag_stall = id_valid & exe_valid & exe_s & (id_cond != 1110).
  - Applies only while freeze=0. While freeze=1, flag_stall=0.
  - AL instructions never stall.
  - The stall lasts exactly one cycle: at the next edge the writer has updated status and leaves Exe, replaced by the bubble the hazard unit inserts.
- cond_pass is qualified: cond_pass = eval(id_cond) & id_valid & !flag_stall.
- Stall counter: increments by 1 on each edge where flag_stall=1 and freeze=0. It saturates at all-ones and does not wrap.

## Timing
- Reset (rst=0, asynchronous): status=0000, stall_count=0. Consequently c_in=0, flag_stall=0, and cond_pass reflects eval with all flags 0 (EQ fails, NE passes).
- Status write latency is 1 cycle: flags are visible on status/c_in/cond_pass the cycle after the writer's Exe cycle.
- c_in during an ADC in Exe is the pre-instruction carry. Back-to-back ADDS then ADCS is correct because ADDS committed at the edge ending its Exe cycle.
- Simultaneous write and condition read: the read uses the old value, and flag_stall covers it.
- freeze=1 holds status and stall_count regardless of the other inputs.
- Reset deasserted mid-stream: the first edge after release behaves normally. No pending-stall state is retained because the hazard is purely combinational from the current stage contents.
- No combinational path from alu_* to any output except through the status register.

## Test plan
- Reset: assert rst=0 mid-run with status=1111 -> status=0000, stall_count=0 immediately, without a clock edge; id_cond=0001 with id_valid=1 -> cond_pass=1.
- Flag write:
  - exe_valid=1, exe_s=1, alu flags N=1,Z=0,C=1,V=0 -> next cycle status=1010 and c_in=1.
  - Same with exe_s=0 -> status unchanged.
- Condition sweep: for status in {0000,0100,0010,1001,1000,0001}, drive all 16 id_cond -> cond_pass matches the table, e.g. status=1001 (N=1,V=1) gives GE=1, LT=0, GT=1; 1111 always 0.
- Hazard:
  - ID EQ while Exe holds SUBS -> flag_stall=1 for exactly one cycle, cond_pass=0 that cycle; next cycle cond_pass reflects the new Z.
  - Same with id_cond=1110 -> flag_stall=0.
  - Same with exe_valid=0 -> flag_stall=0.
- Freeze: hazard conditions present plus freeze=1 for 3 cycles -> flag_stall=0; status and stall_count unchanged; the write occurs on the first edge after freeze drops.
- Saturation: STALL_CNT_W=4 with 20 consecutive stall cycles -> stall_count reaches 15 and holds at 15.

Source files
------------

// File: rtl/status_cond_unit.sv
// status_cond_unit: NZCV status register, ARM condition evaluation, flag hazard stall and stall counter
//   i_clk          system clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_exe_valid    Exe stage holds a real instruction
//   i_exe_s        Exe instruction sets flags
//   i_alu_n/z/c/v  ALU flags this cycle (reach outputs only through r_status)
//   i_id_valid     ID stage holds a real instruction
//   i_id_cond      condition field of the ID instruction
//   i_freeze       global pipeline freeze, holds all state
//   o_status       {N,Z,C,V}
//   o_c_in         stored carry for ADC/SBC
//   o_cond_pass    ID condition holds, qualified by valid and stall
//   o_flag_stall   ID holds and Exe gets a bubble this cycle
//   o_stall_count  saturating count of flag-stall cycles
module status_cond_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_exe_valid,
    input  logic                   i_exe_s,
    input  logic                   i_alu_n,
    input  logic                   i_alu_z,
    input  logic                   i_alu_c,
    input  logic                   i_alu_v,
    input  logic                   i_id_valid,
    input  logic [3:0]             i_id_cond,
    input  logic                   i_freeze,
    output logic [3:0]             o_status,
    output logic                   o_c_in,
    output logic                   o_cond_pass,
    output logic                   o_flag_stall,
    output logic [STALL_CNT_W-1:0] o_stall_count
);
    logic [3:0]             r_status;
    logic [STALL_CNT_W-1:0] r_stall_count;
    logic                   w_write;
    logic                   w_flag_stall;
    logic                   w_eval;
    logic                   w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_status;
    assign w_write      = !i_freeze & i_exe_valid & i_exe_s;
    // ID reads the old flags while a flag-setter sits in Exe; stall instead of forwarding
    assign w_flag_stall = w_write & i_id_valid & (i_id_cond != 4'b1110);

    always_comb begin
        w_eval = 1'b0;
        case (i_id_cond)
            4'b0000: w_eval = w_z;
            4'b0001: w_eval = !w_z;
            4'b0010: w_eval = w_c;
            4'b0011: w_eval = !w_c;
            4'b0100: w_eval = w_n;
            4'b0101: w_eval = !w_n;
            4'b0110: w_eval = w_v;
            4'b0111: w_eval = !w_v;
            4'b1000: w_eval = w_c & !w_z;
            4'b1001: w_eval = !w_c | w_z;
            4'b1010: w_eval = (w_n == w_v);
            4'b1011: w_eval = (w_n != w_v);
            4'b1100: w_eval = !w_z & (w_n == w_v);
            4'b1101: w_eval = w_z | (w_n != w_v);
            4'b1110: w_eval = 1'b1;
            default: w_eval = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status      <= 4'b0000;
            r_stall_count <= '0;
        end else begin
            if (w_write)
                r_status <= {i_alu_n, i_alu_z, i_alu_c, i_alu_v};
            // w_flag_stall already implies !i_freeze
            if (w_flag_stall && !(&r_stall_count))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_status      = r_status;
    assign o_c_in        = r_status[1];
    assign o_flag_stall  = w_flag_stall;
    assign o_cond_pass   = w_eval & i_id_valid & !w_flag_stall;
    assign o_stall_count = r_stall_count;
endmodule

// File: tb/tb_status_cond_unit.sv
// tb_status_cond_unit: directed checks of status_cond_unit (16-bit and 4-bit counter instances)
module tb_status_cond_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exe_valid = 1'b0, exe_s = 1'b0;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_cond = 4'b0000;
    logic        freeze = 1'b0;
    logic [3:0]  status, status_s;
    logic        c_in, cond_pass, flag_stall, c_in_s, cond_pass_s, flag_stall_s;
    logic [15:0] stall_count;
    logic [3:0]  stall_count_s;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    status_cond_unit #(.STALL_CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_exe_valid(exe_valid), .i_exe_s(exe_s),
        .i_alu_n(alu_n), .i_alu_z(alu_z), .i_alu_c(alu_c), .i_alu_v(alu_v),
        .i_id_valid(id_valid), .i_id_cond(id_cond), .i_freeze(freeze),
        .o_status(status), .o_c_in(c_in), .o_cond_pass(cond_pass),
        .o_flag_stall(flag_stall), .o_stall_count(stall_count)
    );

    status_cond_unit #(.STALL_CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_exe_valid(exe_valid), .i_exe_s(exe_s),
        .i_alu_n(alu_n), .i_alu_z(alu_z), .i_alu_c(alu_c), .i_alu_v(alu_v),
        .i_id_valid(id_valid), .i_id_cond(id_cond), .i_freeze(freeze),
        .o_status(status_s), .o_c_in(c_in_s), .o_cond_pass(cond_pass_s),
        .o_flag_stall(flag_stall_s), .o_stall_count(stall_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] f);
        {alu_n, alu_z, alu_c, alu_v} = f;
        exe_valid = 1'b1;
        exe_s = 1'b1;
        id_valid = 1'b0;
        tick();
        exe_valid = 1'b0;
        exe_s = 1'b0;
    endtask

    logic [3:0]  sw_status [6] = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b1000, 4'b0001};
    logic [15:0] sw_mask   [6] = '{16'h56AA, 16'h66A9, 16'h55A6, 16'h565A, 16'h6A9A, 16'h6A6A};

    initial begin
        #2;
        chk("rst_status", status, 4'b0000);
        chk("rst_count", stall_count, 16'd0);
        chk("rst_cin", c_in, 1'b0);
        chk("rst_stall", flag_stall, 1'b0);
        id_valid = 1'b1; id_cond = 4'b0000; #1;
        chk("rst_eq", cond_pass, 1'b0);
        id_cond = 4'b0001; #1;
        chk("rst_ne", cond_pass, 1'b1);
        id_valid = 1'b0;
        #9 rst_n = 1'b1;

        load(4'b1010);
        chk("wr_status", status, 4'b1010);
        chk("wr_cin", c_in, 1'b1);
        exe_valid = 1'b1; exe_s = 1'b0; {alu_n, alu_z, alu_c, alu_v} = 4'b0101;
        tick();
        exe_valid = 1'b0;
        chk("nos_status", status, 4'b1010);

        for (int s = 0; s < 6; s++) begin
            load(sw_status[s]);
            chk("sw_status", status, sw_status[s]);
            id_valid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                id_cond = 4'(c);
                #1;
                chk($sformatf("sweep_s%b_c%b", sw_status[s], id_cond), cond_pass, sw_mask[s][c]);
            end
        end

        // status 0001; SUBS producing zero in Exe, EQ in ID
        exe_valid = 1'b1; exe_s = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b0100;
        id_valid = 1'b1; id_cond = 4'b0000; #1;
        chk("hz_stall", flag_stall, 1'b1);
        chk("hz_pass", cond_pass, 1'b0);
        tick();
        exe_valid = 1'b0; exe_s = 1'b0; #1;
        chk("hz_after_stall", flag_stall, 1'b0);
        chk("hz_after_pass", cond_pass, 1'b1);
        chk("hz_status", status, 4'b0100);
        chk("hz_count", stall_count, 16'd1);

        exe_valid = 1'b1; exe_s = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        id_cond = 4'b1110; #1;
        chk("al_stall", flag_stall, 1'b0);
        chk("al_pass", cond_pass, 1'b1);
        tick();
        chk("al_status", status, 4'b0000);
        chk("al_count", stall_count, 16'd1);

        exe_valid = 1'b0; id_cond = 4'b0000; #1;
        chk("nv_stall", flag_stall, 1'b0);
        chk("nv_pass", cond_pass, 1'b0);

        exe_valid = 1'b1; exe_s = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
        id_cond = 4'b0001; freeze = 1'b1; #1;
        chk("fz_stall", flag_stall, 1'b0);
        chk("fz_pass", cond_pass, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fz_status", status, 4'b0000);
            chk("fz_count", stall_count, 16'd1);
            chk("fz_stall_hold", flag_stall, 1'b0);
        end
        freeze = 1'b0; #1;
        chk("unfz_stall", flag_stall, 1'b1);
        tick();
        exe_valid = 1'b0; exe_s = 1'b0;
        chk("unfz_status", status, 4'b1111);
        chk("unfz_count", stall_count, 16'd2);

        #3 rst_n = 1'b0; #1;
        chk("mrst_status", status, 4'b0000);
        chk("mrst_count", stall_count, 16'd0);
        chk("mrst_cin", c_in, 1'b0);
        id_valid = 1'b1; id_cond = 4'b0001; #1;
        chk("mrst_ne", cond_pass, 1'b1);
        #1 rst_n = 1'b1;
        load(4'b0010);
        chk("post_rst_status", status, 4'b0010);
        chk("post_rst_cin", c_in, 1'b1);

        chk("sat_start", stall_count_s, 4'd0);
        exe_valid = 1'b1; exe_s = 1'b1; id_valid = 1'b1; id_cond = 4'b0000;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_14", stall_count_s, 4'd14);
            if (i == 15) chk("sat_15", stall_count_s, 4'd15);
        end
        chk("sat_hold", stall_count_s, 4'd15);
        chk("wide_20", stall_count, 16'd20);
        exe_valid = 1'b0; exe_s = 1'b0; id_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
